// File: rtl/sim_watchdog_pkg.sv
// rtl/sim_watchdog_pkg.sv - shared types for the simulation watchdog
// Purpose: state enum and fail-code enum used by sim_watchdog.
// Ports: none (package).
package sim_watchdog_pkg;

  localparam int FAIL_CODE_W = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } wd_state_e;

  typedef enum logic [FAIL_CODE_W-1:0] {
    FC_NONE    = 3'd0,
    FC_TIMEOUT = 3'd1,
    FC_MON     = 3'd2,
    FC_MEM     = 3'd3,
    FC_STALL   = 3'd4
  } wd_fail_e;

endpackage

// File: rtl/wd_popcount.sv
// rtl/wd_popcount.sv - population count of a CHANNELS-wide strobe vector
// Purpose: number of set bits in in_i, used to accumulate commits.
// Ports:
//   in_i    - CHANNELS-bit input vector
//   count_o - number of ones in in_i, $clog2(CHANNELS+1) bits
module wd_popcount #(
  parameter int CHANNELS = 8
) (
  input  logic [CHANNELS-1:0]         in_i,
  output logic [$clog2(CHANNELS+1)-1:0] count_o
);

  localparam int PC_W = $clog2(CHANNELS + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count_o = count_o + PC_W'(in_i[i]);
    end
  end

endmodule

// File: rtl/sim_watchdog.sv
// rtl/sim_watchdog.sv - end-of-simulation watchdog: pass/fail decision and run statistics
// Purpose: runs a cycle budget and error monitors; on the first halt waits
//   DRAIN_CYCLES more cycles and declares pass, otherwise latches a fail code.
// Optional feature: macro SIM_WATCHDOG_STALL_EN adds a no-commit stall watchdog.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   timeout_cycles  - cycle budget, sampled while rst is high
//   commit, halt    - per-channel retire strobes and halt indications
//   mon_error       - monitor error level
//   mem_error       - memory model error level
//   done, pass      - terminal flag and verdict (pass valid with done)
//   fail_code       - NONE/TIMEOUT/MON/MEM/STALL
//   halt_chan       - lowest channel halting in the first halt cycle
//   cycles, commits - RUN cycle count (saturating), commit count (wrapping)
module sim_watchdog
  import sim_watchdog_pkg::*;
#(
  parameter int CHANNELS     = 8,
  parameter int CNT_W        = 64,
  parameter int DRAIN_CYCLES = 4,
  parameter int STALL_LIMIT  = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       timeout_cycles,
  input  logic [CHANNELS-1:0]    commit,
  input  logic [CHANNELS-1:0]    halt,
  input  logic                   mon_error,
  input  logic                   mem_error,
  output logic                   done,
  output logic                   pass,
  output logic [FAIL_CODE_W-1:0] fail_code,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] halt_chan,
  output logic [CNT_W-1:0]       cycles,
  output logic [CNT_W-1:0]       commits
);

  localparam int HC_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PC_W    = $clog2(CHANNELS + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  wd_state_e          state_q, state_d;
  wd_fail_e           fail_code_q, fail_code_d;
  logic [CNT_W-1:0]   budget_q, budget_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [CNT_W-1:0]   commits_q, commits_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [HC_W-1:0]    halt_chan_q, halt_chan_d;
  logic [HC_W-1:0]    halt_enc;
  logic [PC_W-1:0]    commit_cnt;

`ifdef SIM_WATCHDOG_STALL_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               stall_hit;
  assign stall_hit = (stall_q >= STALL_W'(STALL_LIMIT));
`endif

  wd_popcount #(
    .CHANNELS(CHANNELS)
  ) u_popcount (
    .in_i   (commit),
    .count_o(commit_cnt)
  );

  // Lowest-index set halt bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    halt_enc = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (halt[i]) halt_enc = HC_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    budget_d    = budget_q;
    cycles_d    = cycles_q;
    commits_d   = commits_q;
    drain_d     = drain_q;
    halt_chan_d = halt_chan_q;
`ifdef SIM_WATCHDOG_STALL_EN
    stall_d     = stall_q;
`endif
    unique case (state_q)
      RUN: begin
        commits_d = commits_q + CNT_W'(commit_cnt);
`ifdef SIM_WATCHDOG_STALL_EN
        if (|commit)         stall_d = '0;
        else if (!stall_hit) stall_d = stall_q + STALL_W'(1);
`endif
        if (mem_error) begin
          state_d     = FAIL;
          fail_code_d = FC_MEM;
        end else if (mon_error) begin
          state_d     = FAIL;
          fail_code_d = FC_MON;
        end else if (budget_q == '0) begin
          // Budget already spent: N RUN cycles were granted, this is edge N+1.
          state_d     = FAIL;
          fail_code_d = FC_TIMEOUT;
`ifdef SIM_WATCHDOG_STALL_EN
        end else if (stall_hit) begin
          state_d     = FAIL;
          fail_code_d = FC_STALL;
`endif
        end else begin
          // A surviving RUN cycle: consume budget and count it.
          budget_d = budget_q - CNT_W'(1);
          if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
          if (|halt) begin
            state_d     = DRAIN;
            halt_chan_d = halt_enc;
            drain_d     = DRAIN_W'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        commits_d = commits_q + CNT_W'(commit_cnt);
        if (mem_error) begin
          state_d     = FAIL;
          fail_code_d = FC_MEM;
        end else if (mon_error) begin
          state_d     = FAIL;
          fail_code_d = FC_MON;
        end else if (drain_q == '0) begin
          state_d = PASS;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: begin
        // PASS and FAIL hold everything until reset.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fail_code_q <= FC_NONE;
      budget_q    <= timeout_cycles;
      cycles_q    <= '0;
      commits_q   <= '0;
      drain_q     <= '0;
      halt_chan_q <= '0;
`ifdef SIM_WATCHDOG_STALL_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      budget_q    <= budget_d;
      cycles_q    <= cycles_d;
      commits_q   <= commits_d;
      drain_q     <= drain_d;
      halt_chan_q <= halt_chan_d;
`ifdef SIM_WATCHDOG_STALL_EN
      stall_q     <= stall_d;
`endif
    end
  end

  // Gated by rst so the flags are low for the whole reset window, even before
  // the first reset edge has loaded the state register.
  assign done      = !rst && ((state_q == PASS) || (state_q == FAIL));
  assign pass      = !rst && (state_q == PASS);
  assign fail_code = fail_code_q;
  assign halt_chan = halt_chan_q;
  assign cycles    = cycles_q;
  assign commits   = commits_q;

endmodule

// File: tb/tb_sim_watchdog.sv
// tb/tb_sim_watchdog.sv - self-checking bench for sim_watchdog
module tb_sim_watchdog;

  localparam int CH = 8;
  localparam int CW = 8;
  localparam int DC = 4;
  localparam int SL = 5;
  localparam int NS = 72;
`ifdef SIM_WATCHDOG_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] timeout_cycles = '0;
  logic [CH-1:0] commit = '0;
  logic [CH-1:0] halt = '0;
  logic          mon_error = 1'b0;
  logic          mem_error = 1'b0;
  logic          done, pass;
  logic [2:0]    fail_code;
  logic [2:0]    halt_chan;
  logic [CW-1:0] cycles, commits;

  sim_watchdog #(
    .CHANNELS(CH), .CNT_W(CW), .DRAIN_CYCLES(DC), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst), .timeout_cycles(timeout_cycles),
    .commit(commit), .halt(halt), .mon_error(mon_error), .mem_error(mem_error),
    .done(done), .pass(pass), .fail_code(fail_code), .halt_chan(halt_chan),
    .cycles(cycles), .commits(commits)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ps;
    bit [2:0]    code;
    bit [2:0]    hc;
    bit [CW-1:0] cyc;
    bit [CW-1:0] com;
    int          edge_n;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            edge_cnt = 0;
  bit            done_seen = 1'b0;
  logic [CH-1:0] s_commit[NS];
  logic [CH-1:0] s_halt[NS];
  bit            s_mon[NS];
  bit            s_mem[NS];

  // Edge 1 is the first rising edge with rst low.
  always @(posedge clk) edge_cnt <= rst ? 0 : edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [CH-1:0] v);
    int i = 0;
    while (i < CH - 1 && !v[i]) i++;
    return i;
  endfunction

  // Outcome from the rules: first deciding edge in RUN by priority, then the
  // drain window of DC+1 edges after the halt edge, errors still winning.
  function automatic exp_t model(input int n);
    exp_t r;
    int   h = 0;
    int   zrun = 0;
    int   sum = 0;
    int   c;
    bit   fin = 1'b0;
    r.ps = 1'b0; r.code = 3'd0; r.hc = 3'd0; r.cyc = '0; r.com = '0; r.edge_n = -1;
    for (int k = 1; k < NS && !fin; k++) begin
      sum += $countones(s_commit[k]);
      if (h == 0) begin
        if (s_mem[k])                      begin r.code = 3'd3; fin = 1'b1; end
        else if (s_mon[k])                 begin r.code = 3'd2; fin = 1'b1; end
        else if (k == n + 1)               begin r.code = 3'd1; fin = 1'b1; end
        else if (STALL_EN && zrun >= SL)   begin r.code = 3'd4; fin = 1'b1; end
        else if (s_halt[k] != '0)          begin h = k; r.hc = 3'(lowest_set(s_halt[k])); end
        zrun = (s_commit[k] == '0) ? zrun + 1 : 0;
      end else begin
        if (s_mem[k])                      begin r.code = 3'd3; fin = 1'b1; end
        else if (s_mon[k])                 begin r.code = 3'd2; fin = 1'b1; end
        else if (k == h + DC + 1)          begin r.ps = 1'b1; fin = 1'b1; end
      end
      if (fin) begin
        r.edge_n = k;
        r.com    = CW'(sum % 256);
        c        = (h != 0) ? h : k - 1;
        r.cyc    = CW'((c > 255) ? 255 : c);
      end
    end
    return r;
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < NS; k++) begin
      s_commit[k] = '0; s_halt[k] = '0; s_mon[k] = 1'b0; s_mem[k] = 1'b0;
    end
  endtask

  task automatic fill_busy_commits();
    for (int k = 1; k < NS; k++) s_commit[k] = CH'($urandom_range(1, 255));
  endtask

  task automatic fill_random();
    for (int k = 1; k < NS; k++) begin
      s_commit[k] = ($urandom_range(0, 2) == 0) ? '0 : CH'($urandom);
      s_halt[k]   = ($urandom_range(0, 24) == 0) ? CH'($urandom_range(1, 255)) : '0;
      s_mon[k]    = ($urandom_range(0, 59) == 0);
      s_mem[k]    = ($urandom_range(0, 79) == 0);
    end
  endtask

  task automatic apply(input int k);
    if (k < NS) begin
      commit = s_commit[k]; halt = s_halt[k]; mon_error = s_mon[k]; mem_error = s_mem[k];
    end else begin
      commit = '0; halt = '0; mon_error = 1'b0; mem_error = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    timeout_cycles = CW'(n);
    apply(NS);
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_cycles", cycles, 0);
    check("rst_commits", commits, 0);
    check("rst_fail_code", fail_code, 0);
    check("rst_halt_chan", halt_chan, 0);
  endtask

  task automatic run_test(input int n);
    exp_t e;
    int   k;
    do_reset(n);
    e = model(n);
    exp_q.push_back(e);
    rst = 1'b0;
    apply(1);
    k = 1;
    while (!done && k < NS + 4) begin
      @(posedge clk);
      #1;
      k++;
      apply(k);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL no_done: done=0 after %0d edges, expected by edge %0d", k, e.edge_n);
      void'(exp_q.pop_back());
    end else begin
      // Terminal state must ignore any further input activity.
      repeat (3) begin
        commit = CH'($urandom); halt = CH'($urandom);
        mon_error = 1'($urandom); mem_error = 1'($urandom);
        @(posedge clk);
        #1;
      end
      check("frozen_done", done, 1);
      check("frozen_pass", pass, e.ps);
      check("frozen_fail_code", fail_code, e.code);
      check("frozen_cycles", cycles, e.cyc);
      check("frozen_commits", commits, e.com);
    end
  endtask

  // Scoreboard monitor: pops one expectation per rising done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_seen = 1'b0;
      end else if (done && !done_seen) begin
        done_seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done=1 with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          check("done_edge", edge_cnt, e.edge_n);
          check("pass", pass, e.ps);
          check("fail_code", fail_code, e.code);
          check("halt_chan", halt_chan, e.hc);
          check("cycles", cycles, e.cyc);
          check("commits", commits, e.com);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "watchdog bench timeout");
  end

  initial begin
    // Timeout with N=10 and N=0, commits busy so no stall can fire.
    clear_stim(); fill_busy_commits(); run_test(10);
    clear_stim(); fill_busy_commits(); run_test(0);
    // Halt on channels 2 and 5 at edge 5: drain then pass.
    clear_stim(); fill_busy_commits(); s_halt[5] = 8'b0010_0100; run_test(40);
    // Monitor error during drain.
    clear_stim(); fill_busy_commits(); s_halt[3] = 8'h80; s_mon[6] = 1'b1; run_test(40);
    // Memory error beats monitor error and halt in the same cycle.
    clear_stim(); fill_busy_commits(); s_mem[4] = 1'b1; s_mon[4] = 1'b1; s_halt[4] = 8'h01; run_test(40);
    // Commit accumulation: 3 x 8 + 1 = 25.
    clear_stim();
    for (int k = 1; k <= 3; k++) s_commit[k] = 8'hFF;
    s_commit[4] = 8'h01; s_halt[4] = 8'h10;
    run_test(40);
    // No commits at all: stall (if enabled) or timeout.
    clear_stim(); run_test(20);
    // Commit counter wrap: 39 x 8 = 312.
    clear_stim();
    for (int k = 1; k <= 39; k++) s_commit[k] = 8'hFF;
    s_halt[39] = 8'h40;
    run_test(45);
    // Timeout edge coincides with a halt: timeout wins.
    clear_stim(); fill_busy_commits(); s_halt[7] = 8'h02; run_test(6);
    // Halt on the last budgeted cycle still drains.
    clear_stim(); fill_busy_commits(); s_halt[6] = 8'h08; run_test(6);
    // Reset asserted mid-drain restarts cleanly.
    clear_stim(); fill_busy_commits(); s_halt[2] = 8'h04;
    do_reset(30);
    rst = 1'b0;
    apply(1);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #1;
      apply(k);
    end
    check("mid_drain_done", done, 0);
    clear_stim(); fill_busy_commits(); s_halt[3] = 8'h20; run_test(25);
    // Randomised runs.
    for (int t = 0; t < 30; t++) begin
      clear_stim();
      fill_random();
      run_test($urandom_range(0, 40));
    end
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: %0d expectations never matched, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
